rv32_processor: RTL and testbench
=================================

// Module: rv32_processor
// PURPOSE
//  Single-cycle RV32I core with Zicsr CSR access: one instruction fetched, executed and retired per clk.
//  Top-level of the CPU; owns PC, decoder, ALU, branch unit and four storage sub-blocks.
//  Storage arrays are preloaded and dumped by hierarchical path, so instance and array names are fixed.
// PARAMETERS
//  IMEM_WORDS  256   instruction memory depth, 32-bit words
//  DMEM_WORDS  256   data memory depth, 32-bit words
//  RESET_PC    0     PC value loaded on reset
// PORTS
//  clk  in  1  system clock; all state updates on rising edge
//  rst  in  1  reset, synchronous, active-high
//  (no other ports; all observation via internal memories)
// BEHAVIOUR
//  Reset: while rst=1 at posedge, pc<=RESET_PC; no RF/DMEM/CSR writes. Memory contents are never cleared by reset.
//  Fetch: inst = inst_mem_i.mem[pc[9:2]], combinational read. pc wraps modulo IMEM size.
//  Each posedge with rst=0: pc<=next_pc and the current instruction retires (RF/DMEM/CSR write).
//  next_pc: pc+4 default; branch taken -> pc+immB; JAL -> pc+immJ; JALR -> (rs1+immI)&~1.
//  Supported: LUI AUIPC JAL JALR, BEQ BNE BLT BGE BLTU BGEU, LW SW,
//   ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI, ADD SUB SLL SLT SLTU XOR OR AND SRL SRA,
//   CSRRW CSRRS CSRRC CSRRWI CSRRSI CSRRCI.
//  Arithmetic: 32-bit, wraps, no overflow traps; shift amount = low 5 bits; SLT signed, SLTU unsigned.
//  Immediates sign-extended per RV32I formats; CSR *I forms zero-extend rs1 field (uimm[4:0]).
//  reg_file_i.reg_mem[32]x32: two comb read ports, one write port at posedge; x0 reads 0, writes to x0 dropped.
//  Same-cycle read of register being written returns OLD value (write lands at edge).
//  data_mem_i.data_mem[DMEM_WORDS]x32: word access only, index = addr[9:2]; comb read, write at posedge.
//  Misaligned LW/SW: low two address bits ignored (no trap).
//  csr_reg_i.csr_mem[4096]x32: indexed by inst[31:20]; comb read, write at posedge.
//  CSR ops: rd<=old CSR; RW: csr<=src; RS: csr<=old|src; RC: csr<=old&~src.
//  CSRRS/CSRRC with rs1=x0 (or uimm=0): no CSR write. CSRRW with rd=x0: rd write dropped (x0 rule).
//  Writeback mux: ALU result | load data | pc+4 (JAL/JALR) | immU (LUI) | pc+immU (AUIPC) | old CSR.
//  Undefined opcode/funct: treated as NOP (no writes, pc+4). No exceptions, interrupts or stalls.
// STRUCTURE
//  Shared package rv32_pkg: opcode constants, funct3/funct7 constants, alu_op_e enum, wb_sel_e enum, imm_sel_e enum.
//  Mandatory instances (hierarchy names fixed): inst_mem_i (array mem), reg_file_i (array reg_mem),
//   data_mem_i (array data_mem), csr_reg_i (array csr_mem).
//  Decoder and ALU combinational in top; optional sub-module alu (name: rv32_alu).
// TESTING
//  Bench: 10-unit clock, rst high first cycle; preload arrays with $readmemb; dump arrays at end of sim.
//  1 x2=5,x4=7; inst 0x002201B3 (add x3,x4,x2) at 0 -> after 1 retire x3=12, pc=4.
//  2 sub/slt: x1=3,x2=-1: sub x5,x1,x2 -> x5=4; slt x6,x2,x1 -> 1; sltu x7,x2,x1 -> 0.
//  3 sw x3,8(x0) then lw x9,8(x0) -> data_mem[2]=12, x9=12; addi x0,x0,5 -> x0 stays 0.
//  4 beq x1,x1,+8 skips next inst -> pc 0->8; jal x1,-8 at 8 -> x1=12, pc=0.
//  5 csr_mem[0x300]=0xF0; csrrs x8,0x300,x1(=3) -> x8=0xF0, csr=0xF3; csrrc x0,0x300,x1 -> csr=0xF0.
//  6 rst asserted mid-program for one posedge -> pc=0 next cycle, RF/DMEM/CSR contents unchanged.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I/Zicsr decode constants and control enums
package rv32_pkg;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_WORD = 3'd2;
    localparam logic [2:0] F3_JALR = 3'd0;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        WB_ALU, WB_MEM, WB_PC4, WB_IMMU, WB_AUIPC, WB_CSR
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        unique case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction
endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I integer ALU
module rv32_alu
    import rv32_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = $signed(a) >>> b[4:0];
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/rv32_storage.sv
// Storage blocks: instruction/data memories, register file, CSR array
module rv32_imem #(
    parameter int WORDS = 256,
    parameter int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

module rv32_dmem #(
    parameter int WORDS = 256,
    parameter int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] data_mem [WORDS];
    always_ff @(posedge clk) if (we) data_mem[addr] <= wdata;
    assign rdata = data_mem[addr];
endmodule

module rv32_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] reg_mem [32];
    always_ff @(posedge clk) if (we && waddr != 5'd0) reg_mem[waddr] <= wdata;
    assign rdata1 = (raddr1 == 5'd0) ? '0 : reg_mem[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : reg_mem[raddr2];
endmodule

module rv32_csr_file (
    input  logic        clk,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] csr_mem [4096];
    always_ff @(posedge clk) if (we) csr_mem[addr] <= wdata;
    assign rdata = csr_mem[addr];
endmodule

// File: rtl/rv32_processor.sv
// Single-cycle RV32I + Zicsr core: fetch, decode, execute, retire per clock
module rv32_processor
    import rv32_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc, next_pc, inst, imm, alu_b, alu_y, wb_data;
    logic [31:0] rs1_data, rs2_data, load_data;
    logic [31:0] csr_old, csr_src, csr_new;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        rf_we, dm_we, csr_we, alu_imm, taken;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    imm_sel_e    imm_sel;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else     pc <= next_pc;
    end

    rv32_imem #(.WORDS(IMEM_WORDS)) inst_mem_i (
        .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
        .raddr(pc[IAW+1:2]), .rdata(inst)
    );

    always_comb begin
        unique case (imm_sel)
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7],
                            inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12],
                            inst[20], inst[30:21], 1'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
    end

    // Unsupported encodings fall through with all write enables low
    always_comb begin
        rf_we   = 1'b0;
        dm_we   = 1'b0;
        csr_we  = 1'b0;
        alu_imm = 1'b1;
        taken   = 1'b0;
        alu_op  = ALU_ADD;
        wb_sel  = WB_ALU;
        imm_sel = IMM_I;
        unique case (opcode)
            OP_LUI: begin
                rf_we = 1'b1; wb_sel = WB_IMMU; imm_sel = IMM_U;
            end
            OP_AUIPC: begin
                rf_we = 1'b1; wb_sel = WB_AUIPC; imm_sel = IMM_U;
            end
            OP_JAL: begin
                rf_we = 1'b1; wb_sel = WB_PC4; imm_sel = IMM_J; taken = 1'b1;
            end
            OP_JALR: begin
                rf_we  = (funct3 == F3_JALR);
                taken  = (funct3 == F3_JALR);
                wb_sel = WB_PC4;
            end
            OP_BRANCH: begin
                imm_sel = IMM_B;
                unique case (funct3)
                    F3_BEQ:  taken = (rs1_data == rs2_data);
                    F3_BNE:  taken = (rs1_data != rs2_data);
                    F3_BLT:  taken = ($signed(rs1_data) < $signed(rs2_data));
                    F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
                    F3_BLTU: taken = (rs1_data < rs2_data);
                    F3_BGEU: taken = (rs1_data >= rs2_data);
                    default: taken = 1'b0;
                endcase
            end
            OP_LOAD: begin
                rf_we = (funct3 == F3_WORD); wb_sel = WB_MEM;
            end
            OP_STORE: begin
                dm_we = (funct3 == F3_WORD); imm_sel = IMM_S;
            end
            OP_IMM: begin
                alu_op = alu_decode(funct3, funct3 == F3_SR && funct7 == F7_ALT);
                if (funct3 == F3_SLL)
                    rf_we = (funct7 == F7_BASE);
                else if (funct3 == F3_SR)
                    rf_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else
                    rf_we = 1'b1;
            end
            OP_REG: begin
                alu_imm = 1'b0;
                alu_op  = alu_decode(funct3, funct7 == F7_ALT);
                rf_we   = (funct7 == F7_BASE) || (funct7 == F7_ALT &&
                          (funct3 == F3_ADD || funct3 == F3_SR));
            end
            OP_SYSTEM: begin
                rf_we  = (funct3[1:0] != 2'b00);
                wb_sel = WB_CSR;
                csr_we = (funct3[1:0] == 2'b01) ||
                         (funct3[1:0] != 2'b00 && rs1 != 5'd0);
            end
            default: ;
        endcase
    end

    assign alu_b = alu_imm ? imm : rs2_data;

    rv32_alu alu_i (.op(alu_op), .a(rs1_data), .b(alu_b), .y(alu_y));

    always_comb begin
        next_pc = pc + 32'd4;
        if (taken)
            next_pc = (opcode == OP_JALR) ? (alu_y & ~32'd1) : (pc + imm);
    end

    assign csr_src = funct3[2] ? {27'b0, rs1} : rs1_data;

    always_comb begin
        unique case (funct3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_old | csr_src;
            2'b11:   csr_new = csr_old & ~csr_src;
            default: csr_new = csr_old;
        endcase
    end

    always_comb begin
        unique case (wb_sel)
            WB_MEM:   wb_data = load_data;
            WB_PC4:   wb_data = pc + 32'd4;
            WB_IMMU:  wb_data = imm;
            WB_AUIPC: wb_data = pc + imm;
            WB_CSR:   wb_data = csr_old;
            default:  wb_data = alu_y;
        endcase
    end

    rv32_regfile reg_file_i (
        .clk(clk), .we(rf_we & ~rst), .waddr(rd), .wdata(wb_data),
        .raddr1(rs1), .raddr2(rs2), .rdata1(rs1_data), .rdata2(rs2_data)
    );

    rv32_dmem #(.WORDS(DMEM_WORDS)) data_mem_i (
        .clk(clk), .we(dm_we & ~rst), .addr(alu_y[DAW+1:2]),
        .wdata(rs2_data), .rdata(load_data)
    );

    rv32_csr_file csr_reg_i (
        .clk(clk), .we(csr_we & ~rst), .addr(inst[31:20]),
        .wdata(csr_new), .rdata(csr_old)
    );
endmodule

// File: tb/tb_rv32_processor.sv
// Directed and random-program bench for rv32_processor against an ISA model
module tb_rv32_processor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_imem [256];
    logic [31:0] m_x    [32];
    logic [31:0] m_dmem [256];
    logic [31:0] m_csr  [4096];
    logic [31:0] m_pc;

    rv32_processor dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(int f7, int r2, int r1, int f3, int rd, int op);
        return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_i(int im, int r1, int f3, int rd, int op);
        return {im[11:0], r1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(int im, int r2, int r1, int f3);
        return {im[11:5], r2[4:0], r1[4:0], f3[2:0], im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int im, int r2, int r1, int f3);
        return {im[12], im[10:5], r2[4:0], r1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int im, int rd);
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6f};
    endfunction

    // ISA-level reference: one instruction per call
    task automatic model_step();
        logic [31:0] in, a, b, iI, iS, iB, iU, iJ, npc, v, old, src, ea;
        logic [6:0] op, f7;
        logic [2:0] f3;
        int rd, r1, r2;
        bit w, t;
        in = m_imem[(m_pc >> 2) % 256];
        op = in[6:0]; f3 = in[14:12]; f7 = in[31:25];
        rd = int'(in[11:7]); r1 = int'(in[19:15]); r2 = int'(in[24:20]);
        a = (r1 == 0) ? 0 : m_x[r1];
        b = (r2 == 0) ? 0 : m_x[r2];
        iI = {{20{in[31]}}, in[31:20]};
        iS = {{20{in[31]}}, in[31:25], in[11:7]};
        iB = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
        iU = {in[31:12], 12'b0};
        iJ = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
        npc = m_pc + 4; w = 0; v = 0;
        case (op)
            7'h37: begin w = 1; v = iU; end
            7'h17: begin w = 1; v = m_pc + iU; end
            7'h6f: begin w = 1; v = m_pc + 4; npc = m_pc + iJ; end
            7'h67: if (f3 == 0) begin w = 1; v = m_pc + 4; npc = (a + iI) & ~32'd1; end
            7'h63: begin
                case (f3)
                    0: t = (a == b);
                    1: t = (a != b);
                    4: t = ($signed(a) < $signed(b));
                    5: t = ($signed(a) >= $signed(b));
                    6: t = (a < b);
                    7: t = (a >= b);
                    default: t = 0;
                endcase
                if (t) npc = m_pc + iB;
            end
            7'h03: if (f3 == 2) begin ea = a + iI; w = 1; v = m_dmem[(ea >> 2) % 256]; end
            7'h23: if (f3 == 2) begin ea = a + iS; m_dmem[(ea >> 2) % 256] = b; end
            7'h13, 7'h33: begin
                logic [31:0] y;
                bit imm_form;
                imm_form = (op == 7'h13);
                y = imm_form ? iI : b;
                w = 1;
                case (f3)
                    0: if (!imm_form && f7 == 7'h20) v = a - y;
                       else if (imm_form || f7 == 0) v = a + y;
                       else w = 0;
                    1: if (f7 == 0) v = a << y[4:0]; else w = 0;
                    5: if (f7 == 0) v = a >> y[4:0];
                       else if (f7 == 7'h20) v = $signed(a) >>> y[4:0];
                       else w = 0;
                    default: begin
                        if (!imm_form && f7 != 0) w = 0;
                        case (f3)
                            2: v = ($signed(a) < $signed(y)) ? 1 : 0;
                            3: v = (a < y) ? 1 : 0;
                            4: v = a ^ y;
                            6: v = a | y;
                            default: v = a & y;
                        endcase
                    end
                endcase
            end
            7'h73: if (f3 != 0 && f3 != 4) begin
                old = m_csr[in[31:20]];
                src = f3[2] ? r1 : a;
                w = 1; v = old;
                case (f3[1:0])
                    1: m_csr[in[31:20]] = src;
                    2: if (r1 != 0) m_csr[in[31:20]] = old | src;
                    default: if (r1 != 0) m_csr[in[31:20]] = old & ~src;
                endcase
            end
            default: ;
        endcase
        if (w && rd != 0) m_x[rd] = v;
        m_pc = npc;
    endtask

    task automatic push_model();
        for (int i = 0; i < 256; i++) begin
            dut.inst_mem_i.mem[i] = m_imem[i];
            dut.data_mem_i.data_mem[i] = m_dmem[i];
        end
        for (int i = 0; i < 32; i++) dut.reg_file_i.reg_mem[i] = m_x[i];
        for (int i = 0; i < 4096; i++) dut.csr_reg_i.csr_mem[i] = m_csr[i];
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin m_imem[i] = 0; m_dmem[i] = 0; end
        for (int i = 0; i < 32; i++) m_x[i] = 0;
        for (int i = 0; i < 4096; i++) m_csr[i] = 0;
    endtask

    task automatic do_reset(input bit load);
        @(negedge clk);
        rst = 1'b1;
        if (load) push_model();
        @(posedge clk); #1;
        m_pc = 0;
        check("reset_pc", 0, dut.pc, m_pc);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk); #1;
            check("pc", i, dut.pc, m_pc);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 32; i++) check("reg", i, dut.reg_file_i.reg_mem[i], m_x[i]);
        for (int i = 0; i < 256; i++) check("dmem", i, dut.data_mem_i.data_mem[i], m_dmem[i]);
        for (int i = 0; i < 4096; i++) check("csr", i, dut.csr_reg_i.csr_mem[i], m_csr[i]);
    endtask

    function automatic logic [31:0] gen(int idx);
        int k, rd, r1, r2, f3, im, ca;
        logic [31:0] v;
        k = $urandom_range(0, 9);
        rd = $urandom_range(0, 7); r1 = $urandom_range(0, 7);
        r2 = $urandom_range(0, 7); f3 = $urandom_range(0, 7);
        im = $urandom_range(0, 4095);
        v = $urandom();
        case (k)
            0, 1: return enc_r(($urandom_range(0, 3) == 0) ? 32 : 0, r2, r1, f3, rd, 'h33);
            2, 3: begin
                if (f3 == 1 || f3 == 5)
                    im = ($urandom_range(0, 1) ? 'h400 : 0) | (im & 31);
                return enc_i(im, r1, f3, rd, 'h13);
            end
            4: return {v[31:12], rd[4:0], ($urandom_range(0, 1) ? 7'h37 : 7'h17)};
            5: return $urandom_range(0, 1) ? enc_i(im, r1, 2, rd, 'h03) : enc_s(im, r2, r1, 2);
            6: return enc_b(4 * $urandom_range(1, 4), r2, r1, f3);
            7: begin
                case ($urandom_range(0, 3))
                    0: ca = 'h300;
                    1: ca = 'h301;
                    2: ca = 'h305;
                    default: ca = im;
                endcase
                return enc_i(ca, r1, f3, rd, 'h73);
            end
            8: return $urandom_range(0, 1) ? enc_j(4 * $urandom_range(1, 3), rd)
                                          : enc_i(4 * idx + 8, 0, 0, rd, 'h67);
            default: return v;
        endcase
    endfunction

    initial begin
        // 1: add x3,x4,x2
        clear_model();
        m_x[2] = 5; m_x[4] = 7; m_imem[0] = 32'h002201B3;
        do_reset(1);
        step(1);
        check("t1_x3", 0, dut.reg_file_i.reg_mem[3], 32'd12);
        check("t1_pc", 0, dut.pc, 32'd4);

        // 2: sub / slt / sltu
        clear_model();
        m_x[1] = 3; m_x[2] = 32'hFFFF_FFFF;
        m_imem[0] = enc_r(32, 2, 1, 0, 5, 'h33);
        m_imem[1] = enc_r(0, 1, 2, 2, 6, 'h33);
        m_imem[2] = enc_r(0, 1, 2, 3, 7, 'h33);
        m_x[7] = 32'hDEAD;
        do_reset(1);
        step(3);
        check("t2_sub", 0, dut.reg_file_i.reg_mem[5], 32'd4);
        check("t2_slt", 0, dut.reg_file_i.reg_mem[6], 32'd1);
        check("t2_sltu", 0, dut.reg_file_i.reg_mem[7], 32'd0);

        // 3: sw / lw / write to x0
        clear_model();
        m_x[3] = 12;
        m_imem[0] = enc_s(8, 3, 0, 2);
        m_imem[1] = enc_i(8, 0, 2, 9, 'h03);
        m_imem[2] = enc_i(5, 0, 0, 0, 'h13);
        do_reset(1);
        step(3);
        check("t3_dmem2", 0, dut.data_mem_i.data_mem[2], 32'd12);
        check("t3_x9", 0, dut.reg_file_i.reg_mem[9], 32'd12);
        check("t3_x0", 0, dut.reg_file_i.reg_mem[0], 32'd0);

        // 4: taken beq then backward jal
        clear_model();
        m_x[1] = 3;
        m_imem[0] = enc_b(8, 1, 1, 0);
        m_imem[1] = enc_i(99, 0, 0, 20, 'h13);
        m_imem[2] = enc_j(-8, 1);
        do_reset(1);
        step(1);
        check("t4_beq_pc", 0, dut.pc, 32'd8);
        step(1);
        check("t4_jal_pc", 0, dut.pc, 32'd0);
        check("t4_link", 0, dut.reg_file_i.reg_mem[1], 32'd12);
        check("t4_skip", 0, dut.reg_file_i.reg_mem[20], 32'd0);

        // 5: csrrs / csrrc
        clear_model();
        m_x[1] = 3; m_csr['h300] = 32'hF0;
        m_imem[0] = enc_i('h300, 1, 2, 8, 'h73);
        m_imem[1] = enc_i('h300, 1, 3, 0, 'h73);
        do_reset(1);
        step(1);
        check("t5_x8", 0, dut.reg_file_i.reg_mem[8], 32'hF0);
        check("t5_csrrs", 0, dut.csr_reg_i.csr_mem['h300], 32'hF3);
        step(1);
        check("t5_csrrc", 0, dut.csr_reg_i.csr_mem['h300], 32'hF0);
        compare_all();

        // 6: reset mid-program blocks the pending csrrw
        clear_model();
        m_dmem[1] = 32'h55; m_csr['h301] = 32'hABC; m_x[11] = 32'h77;
        m_imem[0] = enc_i(1, 10, 0, 10, 'h13);
        m_imem[1] = enc_s(4, 10, 0, 2);
        m_imem[2] = enc_i('h301, 10, 1, 11, 'h73);
        do_reset(1);
        step(2);
        check("t6_pc8", 0, dut.pc, 32'd8);
        do_reset(0);
        check("t6_csr", 0, dut.csr_reg_i.csr_mem['h301], 32'hABC);
        check("t6_x11", 0, dut.reg_file_i.reg_mem[11], 32'h77);
        check("t6_dmem", 0, dut.data_mem_i.data_mem[1], 32'd1);
        step(1);
        check("t6_x10", 0, dut.reg_file_i.reg_mem[10], 32'd2);
        compare_all();

        // random programs against the ISA model
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 256; i++) begin
                m_imem[i] = (i < 48) ? gen(i) : 32'h0;
                m_dmem[i] = $urandom();
            end
            m_x[0] = 0;
            for (int i = 1; i < 32; i++)
                m_x[i] = $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom();
            for (int i = 0; i < 4096; i++) m_csr[i] = $urandom();
            do_reset(1);
            if (run == 5) begin
                step(40);
                do_reset(0);
                step(40);
            end else begin
                step(80);
            end
            compare_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
